// File: rtl/reg_file_if.sv
// Register-file port bundle: one byte-masked write port, two registered read ports.
// The master side is the datapath (decode/writeback); the slave side is the storage.
interface reg_file_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 5
);
    logic                  regWr;
    logic [ADDR_W-1:0]     wrAddr;
    logic [WIDTH/8-1:0]    byteEn;
    logic [WIDTH-1:0]      dataIn;
    logic                  rdEnA;
    logic                  rdEnB;
    logic [ADDR_W-1:0]     rdAddrA;
    logic [ADDR_W-1:0]     rdAddrB;
    logic [WIDTH-1:0]      dataOutA;
    logic [WIDTH-1:0]      dataOutB;
    logic                  wrErr;

    modport master (
        output regWr, wrAddr, byteEn, dataIn, rdEnA, rdEnB, rdAddrA, rdAddrB,
        input  dataOutA, dataOutB, wrErr
    );

    modport slave (
        input  regWr, wrAddr, byteEn, dataIn, rdEnA, rdEnB, rdAddrA, rdAddrB,
        output dataOutA, dataOutB, wrErr
    );
endinterface

// File: rtl/reg_file.sv
// DEPTH x WIDTH register file with byte-enabled write, two registered read ports
// and write-through forwarding; optional hardwired-zero word 0.
module reg_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic        clk,
    input logic        rst_n,
    reg_file_if.slave  bus
);
    localparam int NB = WIDTH / 8;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] oldWord;
    logic [WIDTH-1:0] wrMerged;
    logic [WIDTH-1:0] nextA;
    logic [WIDTH-1:0] nextB;
    logic [WIDTH-1:0] outA;
    logic [WIDTH-1:0] outB;
    logic             err;
    logic             wrInRange;
    logic             wrOk;
    logic             okA;
    logic             okB;

    function automatic logic inRange(input logic [ADDR_W-1:0] a);
        return {{(32-ADDR_W){1'b0}}, a} < 32'(DEPTH);
    endfunction

    function automatic logic isZeroReg(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    assign wrInRange = inRange(bus.wrAddr);
    assign wrOk      = bus.regWr && wrInRange && !isZeroReg(bus.wrAddr);
    assign okA       = inRange(bus.rdAddrA) && !isZeroReg(bus.rdAddrA);
    assign okB       = inRange(bus.rdAddrB) && !isZeroReg(bus.rdAddrB);

    always_comb begin
        oldWord = '0;
        if (wrInRange) oldWord = mem[bus.wrAddr];
    end

    // Post-write value: used both for storage and for same-edge forwarding.
    for (genvar k = 0; k < NB; k++) begin : g_byte
        assign wrMerged[8*k +: 8] = bus.byteEn[k] ? bus.dataIn[8*k +: 8] : oldWord[8*k +: 8];
    end

    always_comb begin
        nextA = '0;
        if (okA) nextA = (wrOk && bus.rdAddrA == bus.wrAddr) ? wrMerged : mem[bus.rdAddrA];
    end

    always_comb begin
        nextB = '0;
        if (okB) nextB = (wrOk && bus.rdAddrB == bus.wrAddr) ? wrMerged : mem[bus.rdAddrB];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            outA <= '0;
            outB <= '0;
            err  <= 1'b0;
        end else begin
            if (wrOk)      mem[bus.wrAddr] <= wrMerged;
            if (bus.rdEnA) outA <= nextA;
            if (bus.rdEnB) outB <= nextB;
            // Zero-register writes are dropped silently; only out-of-range ones flag.
            err <= bus.regWr && !wrInRange;
        end
    end

    assign bus.dataOutA = outA;
    assign bus.dataOutB = outB;
    assign bus.wrErr    = err;
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file (DEPTH=24 so out-of-range addresses exist):
// directed scenarios plus random traffic against an array-based reference model.
module tb_reg_file;
    localparam int WIDTH  = 32;
    localparam int DEPTH  = 24;
    localparam int ADDR_W = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   nTests = 0;
    int   nFail  = 0;

    always #5 clk = ~clk;

    reg_file_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    reg_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference model state
    logic [31:0] mMem [DEPTH];
    logic [31:0] mA, mB;
    logic        mErr;

    function automatic logic [31:0] modelRead(input int a, input logic fwd, input logic [31:0] fwdVal);
        if (a >= DEPTH || a == 0) return 32'h0;
        if (fwd) return fwdVal;
        return mMem[a];
    endfunction

    // Advance the model using the inputs currently applied, then clock the DUT.
    task automatic tick();
        int          wa;
        logic        wValid;
        logic [31:0] newW;
        wa     = int'(bus.wrAddr);
        wValid = bus.regWr && wa < DEPTH && wa != 0;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mMem[i] = 32'h0;
            mA = 32'h0; mB = 32'h0; mErr = 1'b0;
        end else begin
            newW = (wa < DEPTH) ? mMem[wa] : 32'h0;
            for (int k = 0; k < 4; k++)
                if (bus.byteEn[k]) newW[8*k +: 8] = bus.dataIn[8*k +: 8];
            if (bus.rdEnA)
                mA = modelRead(int'(bus.rdAddrA), wValid && bus.rdAddrA == bus.wrAddr, newW);
            if (bus.rdEnB)
                mB = modelRead(int'(bus.rdAddrB), wValid && bus.rdAddrB == bus.wrAddr, newW);
            mErr = bus.regWr && wa >= DEPTH;
            if (wValid) mMem[wa] = newW;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.regWr = 0; bus.wrAddr = '0; bus.byteEn = '0; bus.dataIn = '0;
        bus.rdEnA = 0; bus.rdEnB = 0; bus.rdAddrA = '0; bus.rdAddrB = '0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] be);
        idle();
        bus.regWr = 1; bus.wrAddr = ADDR_W'(a); bus.dataIn = d; bus.byteEn = be;
        tick();
    endtask

    task automatic rd(input int a, input int b);
        idle();
        bus.rdEnA = 1; bus.rdAddrA = ADDR_W'(a);
        bus.rdEnB = 1; bus.rdAddrB = ADDR_W'(b);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 0; idle(); tick(); tick();
        rst_n = 1;
        nTests++; if (bus.dataOutA !== 32'h0) begin nFail++; $display("FAIL reset_outA got=%h exp=0", bus.dataOutA); end
        nTests++; if (bus.dataOutB !== 32'h0) begin nFail++; $display("FAIL reset_outB got=%h exp=0", bus.dataOutB); end
        nTests++; if (bus.wrErr !== 1'b0) begin nFail++; $display("FAIL reset_err got=%b exp=0", bus.wrErr); end
        wr(5, 32'hDEADBEEF, 4'hF);
        rst_n = 0; idle();
        bus.regWr = 1; bus.wrAddr = 5'd6; bus.dataIn = 32'h1234; bus.byteEn = 4'hF;
        tick();
        rst_n = 1;
        rd(5, 6);
        nTests++; if (bus.dataOutA !== 32'h0) begin nFail++; $display("FAIL reset_clear got=%h exp=0", bus.dataOutA); end
        nTests++; if (bus.dataOutB !== 32'h0) begin nFail++; $display("FAIL reset_drop_wr got=%h exp=0", bus.dataOutB); end
        nTests++; if (bus.wrErr !== 1'b0) begin nFail++; $display("FAIL reset_clear_err got=%b exp=0", bus.wrErr); end
    endtask

    task automatic test_basic();
        wr(7, 32'h12345678, 4'hF);
        rd(7, 7);
        nTests++; if (bus.dataOutA !== 32'h12345678) begin nFail++; $display("FAIL basic_A got=%h exp=12345678", bus.dataOutA); end
        nTests++; if (bus.dataOutB !== 32'h12345678) begin nFail++; $display("FAIL basic_B got=%h exp=12345678", bus.dataOutB); end
    endtask

    task automatic test_byte_en();
        wr(3, 32'hAABBCCDD, 4'hF);
        wr(3, 32'h11223344, 4'b0101);
        wr(3, 32'hFFFFFFFF, 4'b0000);
        rd(3, 3);
        nTests++; if (bus.dataOutA !== 32'hAA22CC44) begin nFail++; $display("FAIL byte_en got=%h exp=aa22cc44", bus.dataOutA); end
        nTests++; if (bus.wrErr !== 1'b0) begin nFail++; $display("FAIL byte_en_err got=%b exp=0", bus.wrErr); end
    endtask

    task automatic test_forward();
        wr(9, 32'h0, 4'hF);
        wr(8, 32'h00000088, 4'hF);
        idle();
        bus.regWr = 1; bus.wrAddr = 5'd9; bus.dataIn = 32'hCAFEF00D; bus.byteEn = 4'hF;
        bus.rdEnA = 1; bus.rdAddrA = 5'd9; bus.rdEnB = 1; bus.rdAddrB = 5'd8;
        tick();
        nTests++; if (bus.dataOutA !== 32'hCAFEF00D) begin nFail++; $display("FAIL fwd_A got=%h exp=cafef00d", bus.dataOutA); end
        nTests++; if (bus.dataOutB !== 32'h00000088) begin nFail++; $display("FAIL fwd_B got=%h exp=88", bus.dataOutB); end
        // Partial-byte forward merges with the stored word
        idle();
        bus.regWr = 1; bus.wrAddr = 5'd9; bus.dataIn = 32'h00000011; bus.byteEn = 4'b0001;
        bus.rdEnB = 1; bus.rdAddrB = 5'd9;
        tick();
        nTests++; if (bus.dataOutB !== 32'hCAFEF011) begin nFail++; $display("FAIL fwd_merge got=%h exp=cafef011", bus.dataOutB); end
    endtask

    task automatic test_zero_range();
        wr(0, 32'hFFFFFFFF, 4'hF);
        nTests++; if (bus.wrErr !== 1'b0) begin nFail++; $display("FAIL zero_err got=%b exp=0", bus.wrErr); end
        rd(0, 0);
        nTests++; if (bus.dataOutA !== 32'h0) begin nFail++; $display("FAIL zero_read got=%h exp=0", bus.dataOutA); end
        wr(30, 32'h5A5A5A5A, 4'hF);
        nTests++; if (bus.wrErr !== 1'b1) begin nFail++; $display("FAIL range_err got=%b exp=1", bus.wrErr); end
        rd(30, 7);
        nTests++; if (bus.wrErr !== 1'b0) begin nFail++; $display("FAIL range_err_pulse got=%b exp=0", bus.wrErr); end
        nTests++; if (bus.dataOutA !== 32'h0) begin nFail++; $display("FAIL range_read got=%h exp=0", bus.dataOutA); end
        nTests++; if (bus.dataOutB !== 32'h12345678) begin nFail++; $display("FAIL range_no_alias got=%h exp=12345678", bus.dataOutB); end
        wr(24, 32'h1, 4'hF);
        wr(31, 32'h2, 4'hF);
        nTests++; if (bus.wrErr !== 1'b1) begin nFail++; $display("FAIL range_b2b got=%b exp=1", bus.wrErr); end
    endtask

    task automatic test_hold();
        wr(4, 32'h55, 4'hF);
        rd(4, 4);
        wr(4, 32'h66, 4'hF);
        idle(); tick();
        nTests++; if (bus.dataOutA !== 32'h55) begin nFail++; $display("FAIL hold got=%h exp=55", bus.dataOutA); end
        rd(4, 4);
        nTests++; if (bus.dataOutA !== 32'h66) begin nFail++; $display("FAIL hold_reread got=%h exp=66", bus.dataOutA); end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            bus.regWr   = $urandom_range(0, 1);
            bus.wrAddr  = ADDR_W'($urandom_range(0, 31));
            bus.byteEn  = 4'($urandom_range(0, 15));
            bus.dataIn  = $urandom;
            bus.rdEnA   = ($urandom_range(0, 3) != 0);
            bus.rdEnB   = ($urandom_range(0, 3) != 0);
            // Bias reads toward the write address to exercise forwarding
            bus.rdAddrA = ($urandom_range(0, 3) == 0) ? bus.wrAddr : ADDR_W'($urandom_range(0, 31));
            bus.rdAddrB = ($urandom_range(0, 3) == 0) ? bus.wrAddr : ADDR_W'($urandom_range(0, 31));
            tick();
            nTests++;
            if (bus.dataOutA !== mA || bus.dataOutB !== mB || bus.wrErr !== mErr) begin
                nFail++;
                if (bad < 10)
                    $display("FAIL random cyc=%0d A=%h/%h B=%h/%h err=%b/%b (got/exp)",
                             i, bus.dataOutA, mA, bus.dataOutB, mB, bus.wrErr, mErr);
                bad++;
            end
        end
        rst_n = 1;
    endtask

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_basic();
        test_byte_en();
        test_forward();
        test_zero_range();
        test_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
